// File: rtl/vencoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vencoder_pkg
// Brief  : Shared encoder defaults and masked-parity helper. The matching
//          Viterbi decoder imports this package to build its trellis.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package vencoder_pkg;

  // Default encoder memory and tap polynomials: 1/(1^D^2) feedback, out = w[n].
  localparam int         VENC_MEM_DEFAULT = 2;
  localparam logic [1:0] VENC_FB_DEFAULT  = 2'b10;
  localparam logic [2:0] VENC_FF_DEFAULT  = 3'b001;

  // Widest tap vector ever needed: MEM (max 8) past bits plus the current bit.
  localparam int         VENC_MAX_TAPS    = 9;

  // Parity of the bits of vec selected by mask.
  function automatic logic venc_parity(input logic [VENC_MAX_TAPS-1:0] vec,
                                       input logic [VENC_MAX_TAPS-1:0] mask);
    return ^(vec & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/venc_tap_xor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : venc_tap_xor
// Brief  : Masked XOR reduction over a tap vector with a fixed tap mask.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module venc_tap_xor
  import vencoder_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] MASK  = '1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             parity
);

  // Mask is zero-extended so the shared helper can serve every width.
  localparam logic [VENC_MAX_TAPS-1:0] c_mask_ext = VENC_MAX_TAPS'(MASK);

  // Parity of the tapped bits; purely combinational.
  always_comb begin
    parity = venc_parity(VENC_MAX_TAPS'(vec), c_mask_ext);
  end

endmodule
`default_nettype wire

// File: rtl/vencoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : vencoder
// Brief  : Rate-1 recursive convolutional precoder. One user bit in, one coded
//          bit out per clock: w = in ^ fb(past w), out = ff(w, past w).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module vencoder
  import vencoder_pkg::*;
#(
  parameter int             MEM     = VENC_MEM_DEFAULT,
  parameter logic [MEM-1:0] FB_POLY = MEM'(VENC_FB_DEFAULT),
  parameter logic [MEM:0]   FF_POLY = (MEM+1)'(VENC_FF_DEFAULT)
) (
  input  logic Clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  generate
    if (MEM < 1 || MEM > 8) begin : g_mem_check
      $error("vencoder: MEM must be in 1..8");
    end
  endgenerate

  // r_s[k-1] holds w[n-k]; zero initial values give a known power-up history.
  logic [MEM-1:0] r_s   = '0;
  logic           r_out = 1'b0;

  logic           w_fb;
  logic           w_w;
  logic           w_out_next;
  // Bit 0 is the current w[n], bit k is w[n-k]; matches FF_POLY bit order.
  logic [MEM:0]   w_taps;

  venc_tap_xor #(
    .WIDTH (MEM),
    .MASK  (FB_POLY)
  ) u_fb_xor (
    .vec    (r_s),
    .parity (w_fb)
  );

  // Current recursive bit and the full tap vector for the output path.
  always_comb begin
    w_w    = in ^ w_fb;
    w_taps = {r_s, w_w};
  end

  venc_tap_xor #(
    .WIDTH (MEM + 1),
    .MASK  (FF_POLY)
  ) u_ff_xor (
    .vec    (w_taps),
    .parity (w_out_next)
  );

  // History shift (newest w enters at bit 0) and registered coded output.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_s   <= '0;
      r_out <= 1'b0;
    end else begin
      r_s   <= w_taps[MEM-1:0];
      r_out <= w_out_next;
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_vencoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_vencoder
// Brief  : Self-checking bench for vencoder: default and MEM=1 configurations,
//          directed sequences plus randomized traffic against a bit-level model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_vencoder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic in0   = 1'b0;
  logic in1   = 1'b0;
  logic out0;
  logic out1;

  int checks   = 0;
  int failures = 0;

  // 20 ns clock.
  always #10 clk = ~clk;

  // Default configuration: MEM=2, FB=2'b10, FF=3'b001.
  vencoder dut0 (
    .Clock (clk),
    .reset (reset),
    .in    (in0),
    .out   (out0)
  );

  // Alternate configuration: MEM=1, FB=1'b1, FF=2'b11.
  vencoder #(
    .MEM     (1),
    .FB_POLY (1'b1),
    .FF_POLY (2'b11)
  ) dut1 (
    .Clock (clk),
    .reset (reset),
    .in    (in1),
    .out   (out1)
  );

  // Reference: hist[k-1] is w[n-k]. Counts active taps and takes the count
  // modulo 2, then pushes the new w onto the front of the history.
  function automatic void model_step(input int mem, input bit [8:0] fbp,
                                     input bit [8:0] ffp, input bit inb,
                                     input bit [8:0] hist_in,
                                     output bit [8:0] hist_out,
                                     output bit outb);
    int fbcnt;
    int ffcnt;
    bit w;
    fbcnt = 0;
    for (int k = 1; k <= mem; k++)
      if (fbp[k-1] && hist_in[k-1]) fbcnt++;
    w = inb ^ bit'(fbcnt % 2);
    ffcnt = (ffp[0] && w) ? 1 : 0;
    for (int k = 1; k <= mem; k++)
      if (ffp[k] && hist_in[k-1]) ffcnt++;
    outb = bit'(ffcnt % 2);
    hist_out = '0;
    hist_out[0] = w;
    for (int k = 1; k < mem; k++) hist_out[k] = hist_in[k-1];
  endfunction

  // Drive one bit into dut0 on the falling edge, sample after the rising edge.
  task automatic step0(input bit b);
    @(negedge clk);
    in0 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input bit b);
    @(negedge clk);
    in1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in0 = 1'b0;
    in1 = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (out0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_out0: got %b expected 0", out0);
    end
    checks++;
    if (out1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_out1: got %b expected 0", out1);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // No reset pulse: history is zero from power-up.
  task automatic test_powerup();
    bit exp_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit in_seq  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    in0 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out0 !== 1'b1) begin
      failures++;
      $display("FAIL powerup_first: got %b expected 1", out0);
    end
    for (int i = 1; i < 4; i++) begin
      step0(in_seq[i]);
      checks++;
      if (out0 !== exp_seq[i]) begin
        failures++;
        $display("FAIL powerup_seq[%0d]: got %b expected %b", i, out0, exp_seq[i]);
      end
    end
  endtask

  task automatic test_impulse();
    bit in_seq  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit exp_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    test_reset();
    for (int i = 0; i < 6; i++) begin
      step0(in_seq[i]);
      checks++;
      if (out0 !== exp_seq[i]) begin
        failures++;
        $display("FAIL impulse[%0d]: got %b expected %b", i, out0, exp_seq[i]);
      end
    end
  endtask

  task automatic test_ones();
    bit exp_seq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    test_reset();
    for (int i = 0; i < 8; i++) begin
      step0(1'b1);
      checks++;
      if (out0 !== exp_seq[i]) begin
        failures++;
        $display("FAIL ones[%0d]: got %b expected %b", i, out0, exp_seq[i]);
      end
    end
  endtask

  // Reset asserted between edges must clear out at once; restart from zero.
  task automatic test_midstream_reset();
    test_reset();
    step0(1'b1);
    step0(1'b1);
    checks++;
    if (out0 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: got %b expected 1", out0);
    end
    #4;
    reset = 1'b1;
    #1;
    checks++;
    if (out0 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: got %b expected 0", out0);
    end
    @(negedge clk);
    reset = 1'b0;
    step0(1'b0);
    checks++;
    if (out0 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_post: got %b expected 0", out0);
    end
  endtask

  task automatic test_mem1();
    bit in_seq  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit exp_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    test_reset();
    for (int i = 0; i < 4; i++) begin
      step1(in_seq[i]);
      checks++;
      if (out1 !== exp_seq[i]) begin
        failures++;
        $display("FAIL mem1[%0d]: got %b expected %b", i, out1, exp_seq[i]);
      end
    end
  endtask

  // 500 cycles of random bits into both instances, checked on every falling edge.
  task automatic test_random();
    bit [8:0] h0;
    bit [8:0] h1;
    bit [8:0] hn;
    bit       e0;
    bit       e1;
    bit       b0;
    bit       b1;
    test_reset();
    h0 = '0;
    h1 = '0;
    for (int c = 0; c <= 500; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (out0 !== e0) begin
          failures++;
          $display("FAIL random_def cycle %0d: got %b expected %b", c, out0, e0);
        end
        checks++;
        if (out1 !== e1) begin
          failures++;
          $display("FAIL random_mem1 cycle %0d: got %b expected %b", c, out1, e1);
        end
      end
      if (c < 500) begin
        b0 = bit'($urandom_range(0, 1));
        b1 = bit'($urandom_range(0, 1));
        in0 = b0;
        in1 = b1;
        model_step(2, 9'b000000010, 9'b000000001, b0, h0, hn, e0);
        h0 = hn;
        model_step(1, 9'b000000001, 9'b000000011, b1, h1, hn, e1);
        h1 = hn;
      end
    end
  endtask

  initial begin
    test_powerup();
    test_reset();
    test_impulse();
    test_ones();
    test_midstream_reset();
    test_mem1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
